// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// default widths and a helper that sizes counters from a maximum value.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        HALT  = 2'b10
    } fetch_state_t;

    localparam int DEFAULT_N = 32;
    localparam logic [DEFAULT_N-1:0] DEFAULT_RESET_PC = '0;
    localparam int REDIRECT_W = 16;

    // Smallest bit width (at least 1) able to hold max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Width-parameterised up counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: resolves branch/jump/halt/stall requests into the
// next PC, pipeline flush/hold controls, a stall watchdog and a redirect count.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int             N         = DEFAULT_N,
    parameter logic [N-1:0]   RESET_PC  = N'(DEFAULT_RESET_PC),
    parameter int             STALL_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [N-1:0]          jump_address,
    input  logic                  branch_taken,
    input  logic [N-1:0]          branch_address,
    input  logic                  halt,
    output logic [N-1:0]          pc_out,
    output logic                  ifid_en,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  fetch_valid,
    output logic [1:0]            state,
    output logic                  stall_timeout,
    output logic [REDIRECT_W-1:0] redirect_count
);

    localparam int SW = cnt_width(STALL_MAX);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [N-1:0] pc_d;
    logic         redirect;
    logic         stall_inc;
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_out  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_out  <= pc_d;
        end
    end

    // Priority: branch > jump > halt > stall > increment. HALT freezes
    // everything until reset. A jump is taken in STALL too once stall drops,
    // since that is the cycle decode re-presents it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_out;
        ifid_en  = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        redirect = 1'b0;
        if (!rst) begin
            case (state_q)
                HALT: begin
                end
                default: begin
                    if (branch_taken) begin
                        pc_d     = branch_address;
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                        ifid_en  = 1'b1;
                        redirect = 1'b1;
                        state_d  = RUN;
                    end else if (jump && !stall) begin
                        pc_d     = jump_address;
                        flush_if = 1'b1;
                        ifid_en  = 1'b1;
                        redirect = 1'b1;
                        state_d  = RUN;
                    end else if (halt && !stall) begin
                        flush_if = 1'b1;
                        ifid_en  = 1'b1;
                        state_d  = HALT;
                    end else if (stall) begin
                        state_d  = STALL;
                    end else begin
                        pc_d     = pc_out + 1'b1;
                        ifid_en  = 1'b1;
                        state_d  = RUN;
                    end
                end
            endcase
        end
    end

    assign fetch_valid = (state_q != HALT);
    assign state       = state_q;
    assign stall_inc   = !rst && (state_d == STALL);

    sat_counter #(.W(SW)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!stall_inc),
        .en    (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(REDIRECT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (redirect),
        .count (redirect_count)
    );

    // Set on the edge where the stall run reaches STALL_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_timeout <= 1'b0;
        end else if (stall_inc && (stall_cnt >= STALL_LAST)) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: drivers push per-cycle expectations from a
// rule-level model, monitors pop and compare at the falling edge.
module tb_fetch_ctrl;

    localparam int STALL_MAX = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst = 1'b1, stall = 1'b0, jump = 1'b0, branch_taken = 1'b0, halt = 1'b0;
    logic [31:0] jump_address = '0, branch_address = '0;
    logic [31:0] pc_out;
    logic        ifid_en, flush_if, flush_id, fetch_valid, stall_timeout;
    logic [1:0]  state;
    logic [15:0] redirect_count;

    fetch_ctrl #(.N(32), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_address(jump_address),
        .branch_taken(branch_taken), .branch_address(branch_address), .halt(halt),
        .pc_out(pc_out), .ifid_en(ifid_en), .flush_if(flush_if), .flush_id(flush_id),
        .fetch_valid(fetch_valid), .state(state), .stall_timeout(stall_timeout),
        .redirect_count(redirect_count)
    );

    // 4-bit instance for wrap and saturation
    logic        rst4 = 1'b1, br4 = 1'b0, zero4 = 1'b0;
    logic [3:0]  ba4 = '0, ja4 = '0;
    logic [3:0]  pc4;
    logic        ife4, fif4, fid4, fv4, tmo4;
    logic [1:0]  st4;
    logic [15:0] rc4;

    fetch_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .stall(zero4), .jump(zero4), .jump_address(ja4),
        .branch_taken(br4), .branch_address(ba4), .halt(zero4),
        .pc_out(pc4), .ifid_en(ife4), .flush_if(fif4), .flush_id(fid4),
        .fetch_valid(fv4), .state(st4), .stall_timeout(tmo4), .redirect_count(rc4)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        fv, ife, care_ife, fif, fid, tmo;
        logic [15:0] rc;
    } exp_t;

    typedef struct packed {
        logic [3:0]  pc;
        logic [15:0] rc;
    } exp4_t;

    exp_t  exp_q[$];
    exp4_t exp4_q[$];
    int    total = 0;
    int    bad = 0;
    bit    done_main = 1'b0;
    bit    done_sat = 1'b0;

    // Reference model: spec-level state (mode 0=RUN 1=STALL 2=HALT)
    logic [31:0] m_pc = '0;
    int          m_mode = 0;
    int          m_run = 0;
    bit          m_tmo = 1'b0;
    int          m_rc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] ja,
                         input logic b, input logic [31:0] ba, input logic h);
        exp_t e;
        int   nxt;
        bit   red;
        @(posedge clk);
        #1;
        rst = r; stall = s; jump = j; jump_address = ja;
        branch_taken = b; branch_address = ba; halt = h;
        e.pc = m_pc; e.st = 2'(m_mode); e.fv = (m_mode != 2); e.tmo = m_tmo; e.rc = 16'(m_rc);
        e.fif = 1'b0; e.fid = 1'b0; e.ife = 1'b0; e.care_ife = 1'b1;
        nxt = m_mode; red = 1'b0;
        if (r) begin
            m_pc = '0; nxt = 0; m_run = 0; m_tmo = 1'b0; m_rc = 0;
        end else if (m_mode == 2) begin
            nxt = 2;
        end else if (b) begin
            m_pc = ba; e.fif = 1'b1; e.fid = 1'b1; e.ife = 1'b1; nxt = 0; red = 1'b1;
        end else if (j && !s) begin
            m_pc = ja; e.fif = 1'b1; e.care_ife = 1'b0; nxt = 0; red = 1'b1;
        end else if (h && !s) begin
            e.fif = 1'b1; e.care_ife = 1'b0; nxt = 2;
        end else if (s) begin
            nxt = 1;
        end else begin
            m_pc = m_pc + 1; e.ife = 1'b1; nxt = 0;
        end
        if (!r) begin
            m_run = (nxt == 1) ? m_run + 1 : 0;
            if (m_run >= STALL_MAX) m_tmo = 1'b1;
            if (red && m_rc < 65535) m_rc = m_rc + 1;
        end
        m_mode = nxt;
        exp_q.push_back(e);
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Main stimulus: directed scenarios then random traffic
    initial begin
        repeat (2) @(posedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        free(5);                                   // pc 0..4
        drive(0, 0, 1, 32'h40, 0, 0, 0);           // jump at pc 5
        free(3);                                   // 0x40, 0x41, 0x42
        drive(1, 0, 0, 0, 0, 0, 0);
        free(8);                                   // pc 0..7
        drive(0, 1, 1, 32'h55, 1, 32'h100, 0);     // branch wins at pc 8
        free(2);
        drive(1, 0, 0, 0, 0, 0, 0);
        free(3);
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 0, 0, 0, 0);
        free(3);
        drive(0, 1, 1, 32'h77, 0, 0, 0);           // jump during stall ignored
        drive(0, 0, 1, 32'h77, 0, 0, 0);           // re-presented after stall drops
        free(1);
        drive(1, 0, 0, 0, 0, 0, 0);
        free(32);
        drive(0, 0, 0, 0, 0, 0, 1);                // halt at 0x20
        drive(0, 0, 1, 32'h99, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h123, 0);
        drive(0, 1, 1, 32'h9, 1, 32'h7, 1);
        free(2);
        drive(1, 0, 0, 0, 0, 0, 0);
        free(2);
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 47) == 0));
        end
        done_main = 1'b1;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("state", 32'(state), 32'(e.st));
            chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
            chk("flush_if", 32'(flush_if), 32'(e.fif));
            chk("flush_id", 32'(flush_id), 32'(e.fid));
            if (e.care_ife) chk("ifid_en", 32'(ifid_en), 32'(e.ife));
            chk("stall_timeout", 32'(stall_timeout), 32'(e.tmo));
            chk("redirect_count", 32'(redirect_count), 32'(e.rc));
        end
    end

    // Narrow instance: wrap at 0xF then 65540 back-to-back branches
    initial begin
        logic [3:0] last_ba;
        exp4_t      e;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 rst4 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            e.pc = 4'(k % 16); e.rc = '0;
            exp4_q.push_back(e);
            @(posedge clk);
            #1;
        end
        last_ba = 4'(20 % 16);
        for (int i = 0; i < 65540; i++) begin
            if (i < 3 || i > 65530) begin
                e.pc = last_ba; e.rc = 16'((i < 65535) ? i : 65535);
                exp4_q.push_back(e);
            end
            br4 = 1'b1;
            ba4 = 4'($urandom_range(0, 15));
            last_ba = ba4;
            @(posedge clk);
            #1;
        end
        br4 = 1'b0;
        e.pc = last_ba; e.rc = 16'hFFFF;
        exp4_q.push_back(e);
        @(posedge clk);
        #1 done_sat = 1'b1;
    end

    always @(negedge clk) begin
        if (exp4_q.size() > 0) begin
            exp4_t e;
            e = exp4_q.pop_front();
            chk("n4_pc_out", 32'(pc4), 32'(e.pc));
            chk("n4_redirect_count", 32'(rc4), 32'(e.rc));
        end
    end

    initial begin
        wait (done_main && done_sat);
        @(negedge clk);
        @(negedge clk);
        chk("queues_drained", 32'(exp_q.size() + exp4_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
